// File: rtl/config_pkg.sv
// Shared configuration for the vector functional units.
// Contents:
//   D, FixedPointPrecision - vector length and fixed-point word width
//   fixed_point_t          - signed fixed-point word carried between units
//   FixedMax / FixedMin    - clamp limits of fixed_point_t
//   ternary_t              - 2-bit ternary weight code (2'b10 is reserved)
//   matvec_state_t         - state encoding of ternary_matvec
//   addr_width()           - address width helper that never returns 0
package config_pkg;

  localparam int D                   = 4;
  localparam int FixedPointPrecision = 16;

  typedef logic signed [FixedPointPrecision-1:0] fixed_point_t;

  localparam fixed_point_t FixedMax = {1'b0, {(FixedPointPrecision-1){1'b1}}};
  localparam fixed_point_t FixedMin = {1'b1, {(FixedPointPrecision-1){1'b0}}};

  typedef enum logic [1:0] {
    TernZero = 2'b00,
    TernPos  = 2'b01,
    TernNeg  = 2'b11
  } ternary_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StAccum = 2'b01,
    StWrite = 2'b10
  } matvec_state_t;

  // A depth of 1 still needs a 1-bit address port so the port is never zero-width.
  function automatic int addr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/fixed_saturate.sv
// Clamps a signed value of arbitrary width to the fixed_point_t range.
// This is a raw integer clamp: no bits are dropped from the fraction.
// Ports:
//   i_value - signed input, InWidth bits
//   o_value - clamped result as fixed_point_t
module fixed_saturate
  import config_pkg::*;
#(
  parameter int InWidth = FixedPointPrecision + 1
) (
  input  logic signed [InWidth-1:0] i_value,
  output fixed_point_t              o_value
);

  if (InWidth > FixedPointPrecision) begin : g_clamp
    // The value fits only when every bit from the output sign bit upward agrees.
    logic [InWidth-FixedPointPrecision:0] w_top;
    assign w_top = i_value[InWidth-1:FixedPointPrecision-1];

    // Clamp on disagreement; the input sign bit selects the clamp direction.
    always_comb begin
      if ((&w_top) || !(|w_top)) begin
        o_value = i_value[FixedPointPrecision-1:0];
      end else if (w_top[InWidth-FixedPointPrecision]) begin
        o_value = FixedMin;
      end else begin
        o_value = FixedMax;
      end
    end
  end else begin : g_pass
    // Narrower or equal inputs always fit; the signed cast sign-extends them.
    assign o_value = fixed_point_t'(i_value);
  end

endmodule

// File: rtl/ternary_matvec.sv
// Multiplies an activation vector by a ROWS x COLS ternary weight matrix.
// Each row is accumulated one column per cycle. The row result is then
// saturated and written in a single extra cycle.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   in_ready_o, in_start_i  - start handshake (accepted in IDLE only)
//   done_o                  - pulse coinciding with the last row write
//   vector_addr_o / _r_data - activation memory, combinational read
//   weight_addr_o / _r_data - weight memory, combinational read
//   out_addr_o, out_w_en_o, out_w_data_o - result memory write port
module ternary_matvec
  import config_pkg::*;
#(
  parameter int ROWS     = D,
  parameter int COLS     = D,
  parameter int AccWidth = FixedPointPrecision + $clog2(COLS) + 1,
  localparam int ColW    = addr_width(COLS),
  localparam int WgtW    = addr_width(ROWS * COLS),
  localparam int RowW    = addr_width(ROWS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              in_ready_o,
  input  logic              in_start_i,
  output logic              done_o,
  output logic [ColW-1:0]   vector_addr_o,
  input  fixed_point_t      vector_r_data_i,
  output logic [WgtW-1:0]   weight_addr_o,
  input  logic [1:0]        weight_r_data_i,
  output logic [RowW-1:0]   out_addr_o,
  output logic              out_w_en_o,
  output fixed_point_t      out_w_data_o
);

  localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  matvec_state_t              r_state;
  matvec_state_t              w_state_d;
  logic [RowW-1:0]            r_row;
  logic [RowW-1:0]            w_row_d;
  logic [ColW-1:0]            r_col;
  logic [ColW-1:0]            w_col_d;
  logic signed [AccWidth-1:0] r_acc;
  logic signed [AccWidth-1:0] w_acc_d;
  logic signed [AccWidth-1:0] w_x_ext;
  logic [WgtW-1:0]            w_wgt_addr;
  fixed_point_t               w_sat;

  // The signed cast sign-extends the activation to the accumulator width.
  assign w_x_ext    = AccWidth'(vector_r_data_i);
  assign w_wgt_addr = WgtW'(int'(r_row) * COLS + int'(r_col));

  fixed_saturate #(
    .InWidth (AccWidth)
  ) u_sat (
    .i_value (r_acc),
    .o_value (w_sat)
  );

  // State, row/column counters and accumulator; reset aborts any run in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_row   <= '0;
      r_col   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_row   <= w_row_d;
      r_col   <= w_col_d;
      r_acc   <= w_acc_d;
    end
  end

  // Next-state logic and outputs decoded from the current state and counters.
  always_comb begin
    w_state_d     = r_state;
    w_row_d       = r_row;
    w_col_d       = r_col;
    w_acc_d       = r_acc;
    in_ready_o    = 1'b0;
    done_o        = 1'b0;
    vector_addr_o = '0;
    weight_addr_o = '0;
    out_addr_o    = '0;
    out_w_en_o    = 1'b0;
    out_w_data_o  = '0;

    case (r_state)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_start_i) begin
          w_state_d = StAccum;
          w_row_d   = '0;
          w_col_d   = '0;
          w_acc_d   = '0;
        end else begin
          w_state_d = StIdle;
        end
      end

      StAccum: begin
        vector_addr_o = r_col;
        weight_addr_o = w_wgt_addr;
        // The reserved code 2'b10 falls into the default branch and acts as zero.
        case (ternary_t'(weight_r_data_i))
          TernPos: w_acc_d = r_acc + w_x_ext;
          TernNeg: w_acc_d = r_acc - w_x_ext;
          default: w_acc_d = r_acc;
        endcase
        if (r_col == LastCol) begin
          w_col_d   = '0;
          w_state_d = StWrite;
        end else begin
          w_col_d   = r_col + ColW'(1);
        end
      end

      StWrite: begin
        out_w_en_o   = 1'b1;
        out_addr_o   = r_row;
        out_w_data_o = w_sat;
        w_acc_d      = '0;
        if (r_row == LastRow) begin
          done_o    = 1'b1;
          w_row_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_row_d   = r_row + RowW'(1);
          w_state_d = StAccum;
        end
      end

      default: begin
        w_state_d = StIdle;
        w_row_d   = '0;
        w_col_d   = '0;
        w_acc_d   = '0;
      end
    endcase
  end

endmodule
